// File: rtl/piso.sv
`default_nettype none
// ============================================================================
// Module   : piso
// Purpose  : Parallel-in serial-out transmitter. Accepts a SIZE-bit word over
//            a valid/ready handshake and emits it one bit per enable strobe.
//            A one-word holding buffer lets consecutive words stream without
//            idle bit slots. Sending end of the sipo serial link.
// Revision : 1.0 - initial release
// ============================================================================
module piso #(
  parameter int SIZE      = 8,  // word width, >= 2
  parameter bit SHIFT_DIR = 0   // 0: bit 0 first, 1: bit SIZE-1 first
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            load_valid,
  input  logic [SIZE-1:0] load_data,
  output logic            load_ready,
  output logic            out,
  output logic            out_valid,
  output logic            busy,
  output logic            done
);

  localparam int                 c_cnt_w = $clog2(SIZE);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(SIZE - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic [SIZE-1:0]    r_shreg;
  logic [SIZE-1:0]    r_hold;
  logic               r_hold_full;
  logic [c_cnt_w-1:0] r_bit_count;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic               w_advance;
  logic               w_last_edge;
  logic [c_cnt_w-1:0] w_idx;

  // A word is taken whenever the holding buffer has room.
  assign w_accept    = load_valid && !r_hold_full;
  assign w_advance   = enable && r_busy;
  assign w_last_edge = w_advance && (r_bit_count == c_last);

  // Bit position within the shifter that is currently on the line.
  generate
    if (SHIFT_DIR == 1'b0) begin : g_lsb_first
      assign w_idx = r_bit_count;
    end else begin : g_msb_first
      assign w_idx = c_last - r_bit_count;
    end
  endgenerate

  // Outputs depend on registered state only.
  assign out        = r_busy & r_shreg[w_idx];
  assign out_valid  = r_busy;
  assign busy       = r_busy;
  assign done       = r_done;
  assign load_ready = !r_hold_full;

  // Shifter, holding buffer, bit counter and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_bit_count <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_last_edge) begin
        // Last bit consumed: refill from hold, else bypass an incoming word,
        // else go idle. Hold full implies no accept this edge.
        r_done      <= 1'b1;
        r_bit_count <= '0;
        if (r_hold_full) begin
          r_shreg     <= r_hold;
          r_hold_full <= 1'b0;
        end else if (w_accept) begin
          r_shreg <= load_data;
        end else begin
          r_busy <= 1'b0;
        end
      end else if (w_advance) begin
        r_bit_count <= r_bit_count + c_one;
      end

      if (w_accept && !r_busy) begin
        // Idle shifter: load directly, first bit visible next cycle.
        r_shreg     <= load_data;
        r_bit_count <= '0;
        r_busy      <= 1'b1;
      end else if (w_accept && !w_last_edge) begin
        // Shifter still occupied: park the word in the holding buffer.
        r_hold      <= load_data;
        r_hold_full <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso
// Purpose  : Self-checking bench for piso. Drives an LSB-first and an
//            MSB-first instance with shared stimulus and compares every cycle
//            against a word-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso;

  localparam int c_size = 8;

  logic              clk;
  logic              reset;
  logic              enable;
  logic              load_valid;
  logic [c_size-1:0] load_data;

  logic ready0, out0, valid0, busy0, done0;
  logic ready1, out1, valid1, busy1, done1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: words in flight (head = word on the line) and the
  // number of bits of the head word already sent.
  logic [c_size-1:0] q[$];
  int                k;
  logic              exp_done;

  piso #(.SIZE(c_size), .SHIFT_DIR(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
    .load_data(load_data), .load_ready(ready0), .out(out0),
    .out_valid(valid0), .busy(busy0), .done(done0)
  );

  piso #(.SIZE(c_size), .SHIFT_DIR(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
    .load_data(load_data), .load_ready(ready1), .out(out1),
    .out_valid(valid1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  function automatic logic exp_out(input bit msb_first);
    logic [c_size-1:0] w;
    if (q.size() == 0) return 1'b0;
    w = q[0];
    return msb_first ? w[c_size-1-k] : w[k];
  endfunction

  task automatic check_all();
    logic eb, er;
    eb = (q.size() > 0);
    er = (q.size() < 2);
    chk("out_lsb",   out0,   exp_out(1'b0));
    chk("out_msb",   out1,   exp_out(1'b1));
    chk("valid_lsb", valid0, eb);
    chk("valid_msb", valid1, eb);
    chk("busy_lsb",  busy0,  eb);
    chk("busy_msb",  busy1,  eb);
    chk("ready_lsb", ready0, er);
    chk("ready_msb", ready1, er);
    chk("done_lsb",  done0,  exp_done);
    chk("done_msb",  done1,  exp_done);
  endtask

  task automatic model_reset();
    q.delete();
    k        = 0;
    exp_done = 1'b0;
  endtask

  // One clock cycle: check state, drive inputs, advance model at the edge.
  task automatic cyc(input logic en, input logic lv, input logic [c_size-1:0] d);
    logic acc;
    @(negedge clk);
    check_all();
    enable     = en;
    load_valid = lv;
    load_data  = d;
    @(posedge clk);
    acc      = lv && (q.size() < 2);
    exp_done = 1'b0;
    if (en && q.size() > 0) begin
      if (k == c_size - 1) begin
        void'(q.pop_front());
        k        = 0;
        exp_done = 1'b1;
      end else begin
        k++;
      end
    end
    if (acc) q.push_back(d);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    enable     = 1'b0;
    load_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single word 0x01, enable held high.
    cyc(1'b1, 1'b1, 8'h01);
    repeat (10) cyc(1'b1, 1'b0, 8'h00);

    // 0x12 then 0x34 two cycles later: held, then streamed back-to-back.
    cyc(1'b1, 1'b1, 8'h12);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'h34);
    repeat (18) cyc(1'b1, 1'b0, 8'h00);

    // 0x55, three bits, 0xAA parked in hold, then asynchronous reset.
    cyc(1'b1, 1'b1, 8'h55);
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'hAA);
    cyc(1'b0, 1'b0, 8'h00);
    pulse_reset();
    cyc(1'b1, 1'b1, 8'hFF);
    repeat (10) cyc(1'b1, 1'b0, 8'h00);

    // Bypass: new word offered exactly on the last-bit edge of 0xC3.
    cyc(1'b1, 1'b1, 8'hC3);
    repeat (7) cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'h0F);
    repeat (10) cyc(1'b1, 1'b0, 8'h00);

    // Gated enable with specific words.
    cyc(1'b0, 1'b1, 8'hA5);
    cyc(1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 40; i++) cyc(1'($urandom_range(0, 1)), 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 40; i++) cyc(1'($urandom_range(0, 1)), 1'b0, 8'h00);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
          8'($urandom));
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 8'h00);

    // Reset in the middle of random traffic.
    for (int i = 0; i < 13; i++) cyc(1'b1, 1'b1, 8'($urandom));
    pulse_reset();
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 8'h00);

    @(negedge clk);
    check_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso.md
Name: piso

Overview:
- Parallel-in serial-out transmitter. It is the sending end of the serial link whose receiving end is the team's `sipo` block.
- Accepts a SIZE-bit word over a valid/ready handshake and emits it one bit per `enable` strobe.
- Bit order matches `sipo` for the same SHIFT_DIR setting.
- A one-word holding buffer lets consecutive words stream with no idle bit slots.

Parameters:
SIZE, 8, word width in bits; must be >= 2
SHIFT_DIR, 0, 0 = bit 0 sent first (LSB first); 1 = bit SIZE-1 sent first (MSB first)

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  bit-advance strobe; one bit is consumed per rising edge with enable=1 while busy=1
load_valid  input  1  load_data is valid this cycle
load_data  input  SIZE  parallel word to transmit
load_ready  output  1  block can accept a word this cycle; equals !hold_full
out  output  1  current serial bit
out_valid  output  1  out carries a word bit; equals busy
busy  output  1  a word is in the shifter
done  output  1  one-cycle pulse on the edge that consumes the last bit of a word

Behaviour:
- Internal state:
  - shreg[SIZE-1:0]: active word.
  - hold[SIZE-1:0] and hold_full: buffered next word.
  - bit_count, $clog2(SIZE) bits.
  - busy.
- Reset (asynchronous, immediate): shreg=0, hold=0, hold_full=0, bit_count=0, busy=0, done=0.
  - Resulting outputs: out=0, out_valid=0, load_ready=1.
  - A reset mid-word discards the partial word and any held word; no done pulse is produced.
- All outputs are driven from registers only. There is no combinational path from any input to any output.
- Bit selection:
  - SHIFT_DIR=0: out = shreg[bit_count].
  - SHIFT_DIR=1: out = shreg[SIZE-1-bit_count].
  - When busy=0, out is forced to 0.
- Accept: a word is accepted on an edge where load_valid && load_ready. It goes to the shifter or to the holding buffer:
  - Direct to shifter: the shifter is free (busy=0) or finishing this edge (last-bit edge), and hold is empty. Then shreg<=load_data, bit_count<=0, busy<=1. The first bit appears on out the cycle after the accept edge (latency 1).
  - To hold: otherwise. hold<=load_data, hold_full<=1, so load_ready drops on the next cycle.
- Bit advance: on an edge with enable=1 && busy=1:
  - If bit_count < SIZE-1: bit_count<=bit_count+1, done<=0.
  - If bit_count = SIZE-1 (last-bit edge): done<=1, bit_count<=0, then one of:
    - if hold_full: shreg<=hold, hold_full<=0, busy stays 1. This gives back-to-back words with no gap.
    - else if an accept occurs on the same edge: direct load as above, busy stays 1.
    - else busy<=0.
- Any edge not producing a done pulse drives done<=0. done is exactly one cycle wide.
- enable=1 while busy=0 is ignored: no state change, no done.
- enable=0 freezes bit_count; out holds its value indefinitely.
- A hold buffer fill and a hold-to-shifter transfer never occur on the same edge, because load_ready=0 while hold_full=1.
- Pairing with `sipo` (same SIZE and SHIFT_DIR): connect sipo.in=out and sipo.enable = enable & out_valid. The sipo done pulse coincides with the piso done pulse, and sipo.out equals the loaded word.
- bit_count never exceeds SIZE-1. Wrap to 0 happens only at the last-bit edge.

Test Plan:
- SIZE=8, SHIFT_DIR=0, idle, accept 0x01, enable held at 1 -> out = 1,0,0,0,0,0,0,0 on the 8 cycles after accept; done pulses at the 8th enable edge; busy=0 afterwards; load_ready=1 throughout.
- SHIFT_DIR=1, accept 0x01, enable=1 -> out = 0,0,0,0,0,0,0,1; done on the 8th edge.
- Accept 0x12, then accept 0x34 two cycles later while busy -> load_ready=0 until the first last-bit edge; 16 contiguous bits, LSB first 0x12 then 0x34; busy never drops between words; done pulses twice, 8 edges apart.
- Pseudo-random enable (~50% duty), loopback into sipo with sipo.enable=enable&out_valid, words 0xA5, 0x3C, 0xFF -> sipo.out matches each word at its done; out stable while enable=0; piso and sipo done coincide.
- Accept 0x55, then after 3 enabled bits accept 0xAA (hold full), then assert reset for 1 cycle -> immediately out=0, busy=0, done=0, load_ready=1; a subsequent 0xFF serialises all ones from bit 0, with done on the 8th edge.
- Hold empty, load_valid=1 with 0x0F on the last-bit edge of a prior word -> bypass load, no gap cycle, next out=1 (bit 0 of 0x0F), load_ready stays 1.
